// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. The WIDTH-bit carry chain is cut into STAGES
// registered chunks, and the result is returned through a valid/ready handshake.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int W = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // A single enable moves every stage at once. It depends only on registered
  // out_valid and on out_ready, so in_valid never reaches out_valid combinationally.
  // NOTE: each always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    advance = !out_valid || out_ready;
    b_eff   = sub ? ~b : b;
    c0      = sub ? 1'b1 : cin;
  end

  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_W = (k + 1) * W;    // result bits resolved once this stage is done
    localparam int UP_W = WIDTH - k * W;  // operand bits not yet consumed on entry

    logic [UP_W-1:0] a_up;
    logic [UP_W-1:0] b_up;
    logic            c_in;
    logic            v_in;
    logic [W-1:0]    part;
    logic            c_d, c_q;
    logic            v_d, v_q;
    logic [LO_W-1:0] s_d, s_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_up = a;
        b_up = b_eff;
        c_in = c0;
        v_in = in_valid;
        s_d  = part;
      end
    end else begin : g_src
      always_comb begin
        a_up = g_stage[k-1].g_skew.a_hi_q;
        b_up = g_stage[k-1].g_skew.b_hi_q;
        c_in = g_stage[k-1].c_q;
        v_in = g_stage[k-1].v_q;
        s_d  = {part, g_stage[k-1].s_q};
      end
    end

    always_comb begin
      {c_d, part} = {1'b0, a_up[W-1:0]} + {1'b0, b_up[W-1:0]} + {{W{1'b0}}, c_in};
      v_d         = v_in;
    end

    // NOTE: data registers are reset along with the valid bits, so sum/cout/ovf read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: state updates use <= so each stage samples its neighbour's pre-edge value.
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    // Upper operand chunks ride along until the stage that consumes them.
    if (k < STAGES - 1) begin : g_skew
      logic [UP_W-W-1:0] a_hi_d, a_hi_q;
      logic [UP_W-W-1:0] b_hi_d, b_hi_q;

      always_comb begin
        a_hi_d = a_up[UP_W-1:W];
        b_hi_d = b_up[UP_W-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (advance) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end

    // The carry into the MSB is recovered from the MSB operand bits and the sum bit.
    if (k == STAGES - 1) begin : g_last
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = (a_up[UP_W-1] ^ b_up[UP_W-1] ^ part[W-1]) ^ c_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stage[STAGES-1].v_q;
    sum       = g_stage[STAGES-1].s_q;
    cout      = g_stage[STAGES-1].c_q;
    ovf       = g_stage[STAGES-1].g_last.ovf_q;
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16/4 main instance, plus 16/1 and 8/2
// instances sharing the same stimulus for the degenerate-depth cases.
module tb_pipelined_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sub;
  logic        cin;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;

  logic        in_ready0, out_valid0, cout0, ovf0;
  logic [15:0] sum0;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] sum1;
  logic        in_ready2, out_valid2, cout2, ovf2;
  logic [7:0]  sum2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] exp_q[$];
  int          lat0, lat1, lat2;
  logic [17:0] res0, res1;
  logic [9:0]  res2;

  logic [15:0] sa [8] = '{16'h3A5C, 16'hFFFF, 16'h8001, 16'h1234,
                          16'h7FFF, 16'h0000, 16'hC0DE, 16'h5555};
  logic [15:0] sb [8] = '{16'h1F2E, 16'h0001, 16'h8000, 16'h4321,
                          16'h7FFF, 16'h0001, 16'hBEEF, 16'hAAAA};
  logic [7:0]  ss = 8'b0110_1010;
  logic [7:0]  sc = 8'b1000_0101;
  logic [7:0]  gp = 8'b0110_0101;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
    .out_valid(out_valid2), .out_ready(out_ready),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic c, input logic o, input logic [15:0] s);
    return {14'd0, c, o, s};
  endfunction

  // Reference: two's-complement overflow from operand/result sign agreement.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic s, input logic c);
    logic [15:0] bb;
    logic        cc;
    logic [16:0] full;
    logic        ov;
    bb   = s ? ~bv : bv;
    cc   = s ? 1'b1 : c;
    full = {1'b0, av} + {1'b0, bb} + {16'd0, cc};
    ov   = (av[15] == bb[15]) && (full[15] != av[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  // One cycle of scoreboarded traffic on dut0; called just after the negedge settle.
  task automatic sb_step();
    if (out_valid0 && out_ready) begin
      if (exp_q.size() == 0) check("unexpected beat", 32'(exp_q.size()), 32'd1);
      else check("stream result", 32'({cout0, ovf0, sum0}), 32'(exp_q.pop_front()));
    end
    if (in_valid && in_ready0) exp_q.push_back(model(a, b, sub, cin));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single beat into empty pipelines; records first-valid latency and result per instance.
  task automatic run_one(input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic c);
    a = av; b = bv; sub = s; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    lat0 = 0; lat1 = 0; lat2 = 0;
    res0 = '0; res1 = '0; res2 = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (lat0 == 0 && out_valid0) begin lat0 = i; res0 = {cout0, ovf0, sum0}; end
      if (lat1 == 0 && out_valid1) begin lat1 = i; res1 = {cout1, ovf1, sum1}; end
      if (lat2 == 0 && out_valid2) begin lat2 = i; res2 = {cout2, ovf2, sum2}; end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int idx;
    int n_out;
    int last_out;
    int vcount;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    check("reset out_valid", 32'(out_valid0), 32'd0);
    check("reset sum/cout/ovf", 32'({cout0, ovf0, sum0}), pk(1'b0, 1'b0, 16'h0000));
    check("reset in_ready", 32'(in_ready0), 32'd1);
    check("reset out_valid s1", 32'(out_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("ffff+1 result", 32'(res0), pk(1'b1, 1'b0, 16'h0000));
    check("ffff+1 latency", 32'(lat0), 32'd4);
    check("ffff+1 result s1", 32'(res1), pk(1'b1, 1'b0, 16'h0000));

    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("7fff+1 result", 32'(res0), pk(1'b0, 1'b1, 16'h8000));

    run_one(16'h00FF, 16'h0000, 1'b0, 1'b1);
    check("00ff+0+cin result", 32'(res0), pk(1'b0, 1'b0, 16'h0100));

    run_one(16'h0005, 16'h0007, 1'b1, 1'b0);
    check("5-7 result", 32'(res0), pk(1'b0, 1'b0, 16'hFFFE));

    run_one(16'h8000, 16'h0001, 1'b1, 1'b1);
    check("8000-1 result", 32'(res0), pk(1'b1, 1'b1, 16'h7FFF));
    check("8000-1 result s1", 32'(res1), pk(1'b1, 1'b1, 16'h7FFF));

    // Eight back-to-back beats, out_ready low for cycles 6..8.
    idx = 0; n_out = 0; last_out = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a = sa[idx]; b = sb[idx]; sub = ss[idx]; cin = sc[idx];
      end
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        check("stall in_ready", 32'(in_ready0), 32'd0);
        check("stall out_valid", 32'(out_valid0), 32'd1);
        check("stall frozen output", 32'({cout0, ovf0, sum0}),
              32'(model(sa[2], sb[2], ss[2], sc[2])));
      end
      if (out_valid0 && out_ready) begin
        n_out++;
        last_out = cyc;
      end
      acc = in_valid && in_ready0;
      sb_step();
      if (acc) idx++;
    end
    check("stream beats out", 32'(n_out), 32'd8);
    check("stream last out cycle", 32'(last_out), 32'd14);
    check("stream leftovers", 32'(exp_q.size()), 32'd0);

    // Input gaps of 1 and 2 cycles must reappear on out_valid four cycles later.
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_valid = (cyc < 8) ? gp[cyc] : 1'b0;
      a = 16'h0F00 + 16'(cyc * 37);
      b = 16'h00FF + 16'(cyc);
      sub = 1'b0; cin = 1'b1;
      #1;
      if (cyc >= 4 && cyc < 12) check("gap out_valid", 32'(out_valid0), 32'(gp[cyc-4]));
      sb_step();
    end
    check("gap leftovers", 32'(exp_q.size()), 32'd0);

    // Three beats in flight, then an asynchronous reset mid-cycle.
    sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h1234 + 16'(i);
      b = 16'h1111;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre-reset out_valid", 32'(out_valid0), 32'd1);
    check("pre-reset sum", 32'(sum0), 32'h2345);
    #1 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid0), 32'd0);
    check("async reset sum", 32'(sum0), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid0) vcount++;
    end
    check("no stale beat after reset", 32'(vcount), 32'd0);

    run_one(16'h000F, 16'h0001, 1'b0, 1'b0);
    check("post-reset latency", 32'(lat0), 32'd4);
    check("0f+1 result", 32'(res0), pk(1'b0, 1'b0, 16'h0010));
    check("0f+1 latency s1", 32'(lat1), 32'd1);
    check("0f+1 result s1", 32'(res1), pk(1'b0, 1'b0, 16'h0010));
    check("0f+1 latency w8s2", 32'(lat2), 32'd2);
    check("0f+1 result w8s2", 32'(res2), 32'h010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
